// File: rtl/pipelined_controller.sv
// ============================================================================
// Module   : pipelined_controller
// Purpose  : EX-stage decoder with WB control registers, WB->EX forwarding,
//            multi-cycle multiply stall and a bank of GPIO CSRs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_controller #(
    parameter int          NUM_GPIO    = 2,
    parameter logic [11:0] CSR_BASE    = 12'hF00,
    parameter int          MUL_LATENCY = 3
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           valid_EX,
    input  logic [6:0]                                     opcode_EX,
    input  logic [2:0]                                     funct3_EX,
    input  logic [6:0]                                     funct7_EX,
    input  logic [11:0]                                    csr_EX,
    input  logic [4:0]                                     rs1_EX,
    input  logic [4:0]                                     rs2_EX,
    input  logic [4:0]                                     rd_EX,
    output logic                                           alusrc,
    output logic [3:0]                                     aluop,
    output logic [NUM_GPIO-1:0]                            gpio_we,
    output logic [((NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1)-1:0] gpio_rsel,
    output logic                                           illegal,
    output logic                                           stall,
    output logic                                           fwd_a,
    output logic                                           fwd_b,
    output logic                                           regwrite_WB,
    output logic [1:0]                                     regsel_WB,
    output logic [4:0]                                     rd_WB
);

    localparam int c_RSEL_W = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1;
    localparam int c_CNT_W  = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MUL_LATENCY - 1);

    localparam logic [6:0] c_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OP_REG = 7'b0110011;
    localparam logic [6:0] c_OP_LUI = 7'b0110111;
    localparam logic [6:0] c_OP_SYS = 7'b1110011;

    localparam logic [3:0] c_ALU_XOR   = 4'b0000;
    localparam logic [3:0] c_ALU_AND   = 4'b0001;
    localparam logic [3:0] c_ALU_OR    = 4'b0010;
    localparam logic [3:0] c_ALU_ADD   = 4'b0011;
    localparam logic [3:0] c_ALU_SUB   = 4'b0100;
    localparam logic [3:0] c_ALU_MUL   = 4'b0101;
    localparam logic [3:0] c_ALU_MULH  = 4'b0110;
    localparam logic [3:0] c_ALU_MULHU = 4'b0111;
    localparam logic [3:0] c_ALU_SLL   = 4'b1000;
    localparam logic [3:0] c_ALU_SRL   = 4'b1001;
    localparam logic [3:0] c_ALU_SRA   = 4'b1010;
    localparam logic [3:0] c_ALU_SLT   = 4'b1100;
    localparam logic [3:0] c_ALU_SLTU  = 4'b1101;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;

    logic        w_alusrc;
    logic [3:0]  w_aluop;
    logic        w_wr;
    logic [1:0]  w_sel;
    logic        w_is_mul;
    logic        w_is_csr;
    logic        w_legal;
    logic        w_ok;
    logic        w_csr_ok;
    logic [12:0] w_csr_off;
    logic        w_csr_hit;

    // Extra top bit catches addresses below CSR_BASE as a borrow.
    assign w_csr_off = {1'b0, csr_EX} - {1'b0, CSR_BASE};
    assign w_csr_hit = !w_csr_off[12] && (w_csr_off < 13'(NUM_GPIO));

    always_comb begin
        w_alusrc = 1'b0;
        w_aluop  = c_ALU_XOR;
        w_wr     = 1'b0;
        w_sel    = 2'b00;
        w_is_mul = 1'b0;
        w_is_csr = 1'b0;
        w_legal  = 1'b0;
        case (opcode_EX)
            c_OP_IMM: begin
                w_alusrc = 1'b1;
                w_wr     = 1'b1;
                w_sel    = 2'b10;
                w_legal  = 1'b1;
                case (funct3_EX)
                    3'b000:  w_aluop = c_ALU_ADD;
                    3'b111:  w_aluop = c_ALU_AND;
                    3'b110:  w_aluop = c_ALU_OR;
                    3'b100:  w_aluop = c_ALU_XOR;
                    3'b010:  w_aluop = c_ALU_SLT;
                    3'b011:  w_aluop = c_ALU_SLTU;
                    3'b001: begin
                        w_aluop = c_ALU_SLL;
                        w_legal = (funct7_EX == 7'b0000000);
                    end
                    default: begin
                        if (funct7_EX == 7'b0000000)
                            w_aluop = c_ALU_SRL;
                        else if (funct7_EX == 7'b0100000)
                            w_aluop = c_ALU_SRA;
                        else
                            w_legal = 1'b0;
                    end
                endcase
            end
            c_OP_REG: begin
                w_wr    = 1'b1;
                w_sel   = 2'b10;
                w_legal = 1'b1;
                if (funct7_EX == 7'b0000000) begin
                    case (funct3_EX)
                        3'b000:  w_aluop = c_ALU_ADD;
                        3'b111:  w_aluop = c_ALU_AND;
                        3'b110:  w_aluop = c_ALU_OR;
                        3'b100:  w_aluop = c_ALU_XOR;
                        3'b001:  w_aluop = c_ALU_SLL;
                        3'b101:  w_aluop = c_ALU_SRL;
                        3'b010:  w_aluop = c_ALU_SLT;
                        default: w_aluop = c_ALU_SLTU;
                    endcase
                end else if (funct7_EX == 7'b0100000) begin
                    if (funct3_EX == 3'b000)
                        w_aluop = c_ALU_SUB;
                    else if (funct3_EX == 3'b101)
                        w_aluop = c_ALU_SRA;
                    else
                        w_legal = 1'b0;
                end else if (funct7_EX == 7'b0000001) begin
                    w_is_mul = 1'b1;
                    if (funct3_EX == 3'b000)
                        w_aluop = c_ALU_MUL;
                    else if (funct3_EX == 3'b001)
                        w_aluop = c_ALU_MULH;
                    else if (funct3_EX == 3'b011)
                        w_aluop = c_ALU_MULHU;
                    else
                        w_legal = 1'b0;
                end else begin
                    w_legal = 1'b0;
                end
            end
            c_OP_LUI: begin
                w_wr    = 1'b1;
                w_sel   = 2'b01;
                w_aluop = c_ALU_ADD;
                w_legal = 1'b1;
            end
            c_OP_SYS: begin
                if (funct3_EX == 3'b001 && w_csr_hit) begin
                    w_wr     = 1'b1;
                    w_sel    = 2'b00;
                    w_is_csr = 1'b1;
                    w_legal  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Every decoded control is masked by w_ok so bubbles and illegal
    // encodings present all-zero controls downstream.
    assign w_ok     = valid_EX && w_legal;
    assign w_csr_ok = w_ok && w_is_csr;
    assign illegal  = valid_EX && !w_legal;
    assign alusrc   = w_ok && w_alusrc;
    assign aluop    = w_ok ? w_aluop : 4'b0000;
    assign gpio_rsel = w_csr_ok ? w_csr_off[c_RSEL_W-1:0] : '0;

    always_comb begin
        gpio_we = '0;
        for (int i = 0; i < NUM_GPIO; i++)
            gpio_we[i] = w_csr_ok && !stall && (w_csr_off == 13'(i));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        stall       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ok && w_is_mul && (MUL_LATENCY > 1)) begin
                    stall       = 1'b1;
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = c_CNT_W'(1);
                end
            end
            S_BUSY: begin
                if (!valid_EX) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != c_CNT_LAST) begin
                    stall     = 1'b1;
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_WB <= 1'b0;
            regsel_WB   <= 2'b00;
            rd_WB       <= 5'd0;
        end else if (w_ok && !stall) begin
            regwrite_WB <= w_wr && (rd_EX != 5'd0);
            regsel_WB   <= w_sel;
            rd_WB       <= rd_EX;
        end else begin
            regwrite_WB <= 1'b0;
        end
    end

    assign fwd_a = regwrite_WB && (rd_WB != 5'd0) && (rd_WB == rs1_EX);
    assign fwd_b = regwrite_WB && (rd_WB != 5'd0) && (rd_WB == rs2_EX);

endmodule

`default_nettype wire

// File: tb/tb_pipelined_controller.sv
// ============================================================================
// Module   : tb_pipelined_controller
// Purpose  : Directed vector table plus multi-cycle sequences for the
//            EX/WB controller (NUM_GPIO=4; MUL_LATENCY=3 and 1 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_controller;

    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] OPR = 7'b0110011;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] SYS = 7'b1110011;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_EX;
    logic [6:0]  opcode_EX;
    logic [2:0]  funct3_EX;
    logic [6:0]  funct7_EX;
    logic [11:0] csr_EX;
    logic [4:0]  rs1_EX, rs2_EX, rd_EX;

    logic        alusrc, illegal, stall, fwd_a, fwd_b, regwrite_WB;
    logic [3:0]  aluop, gpio_we;
    logic [1:0]  gpio_rsel, regsel_WB;
    logic [4:0]  rd_WB;

    logic        alusrc1, illegal1, stall1, fwd_a1, fwd_b1, regwrite_WB1;
    logic [3:0]  aluop1, gpio_we1;
    logic [1:0]  gpio_rsel1, regsel_WB1;
    logic [4:0]  rd_WB1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipelined_controller #(.NUM_GPIO(4), .CSR_BASE(12'hF00), .MUL_LATENCY(3)) u_dut (
        .clk(clk), .rst(rst), .valid_EX(valid_EX), .opcode_EX(opcode_EX),
        .funct3_EX(funct3_EX), .funct7_EX(funct7_EX), .csr_EX(csr_EX),
        .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX),
        .alusrc(alusrc), .aluop(aluop), .gpio_we(gpio_we), .gpio_rsel(gpio_rsel),
        .illegal(illegal), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .regwrite_WB(regwrite_WB), .regsel_WB(regsel_WB), .rd_WB(rd_WB)
    );

    pipelined_controller #(.NUM_GPIO(4), .CSR_BASE(12'hF00), .MUL_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .valid_EX(valid_EX), .opcode_EX(opcode_EX),
        .funct3_EX(funct3_EX), .funct7_EX(funct7_EX), .csr_EX(csr_EX),
        .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX),
        .alusrc(alusrc1), .aluop(aluop1), .gpio_we(gpio_we1), .gpio_rsel(gpio_rsel1),
        .illegal(illegal1), .stall(stall1), .fwd_a(fwd_a1), .fwd_b(fwd_b1),
        .regwrite_WB(regwrite_WB1), .regsel_WB(regsel_WB1), .rd_WB(rd_WB1)
    );

    typedef struct {
        logic        v;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] csr;
        logic [4:0]  rd;
        logic        e_alusrc;
        logic [3:0]  e_aluop;
        logic        e_ill;
        logic [3:0]  e_we;
        logic [1:0]  e_rsel;
        logic        e_rw;
        logic [1:0]  e_sel;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(logic v, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                logic [11:0] csr, logic [4:0] rd, logic e_alusrc,
                                logic [3:0] e_aluop, logic e_ill, logic [3:0] e_we,
                                logic [1:0] e_rsel, logic e_rw, logic [1:0] e_sel,
                                logic [4:0] e_rd);
        vec_t t;
        t.v = v; t.op = op; t.f3 = f3; t.f7 = f7; t.csr = csr; t.rd = rd;
        t.e_alusrc = e_alusrc; t.e_aluop = e_aluop; t.e_ill = e_ill; t.e_we = e_we;
        t.e_rsel = e_rsel; t.e_rw = e_rw; t.e_sel = e_sel; t.e_rd = e_rd;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive at the falling edge and settle 2ns before any comparison.
    task automatic drv(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [11:0] csr, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd);
        @(negedge clk);
        valid_EX = v; opcode_EX = op; funct3_EX = f3; funct7_EX = f7;
        csr_EX = csr; rs1_EX = rs1; rs2_EX = rs2; rd_EX = rd;
        #2;
    endtask

    task automatic edge_clk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(1, OPI, 3'b000, 7'h00, 12'h000, 5'd5,  1, 4'b0011, 0, 4'b0000, 2'd0, 1, 2'b10, 5'd5);
        tbl[1]  = mk(1, OPI, 3'b100, 7'h00, 12'h000, 5'd8,  1, 4'b0000, 0, 4'b0000, 2'd0, 1, 2'b10, 5'd8);
        tbl[2]  = mk(1, OPI, 3'b101, 7'h20, 12'h000, 5'd9,  1, 4'b1010, 0, 4'b0000, 2'd0, 1, 2'b10, 5'd9);
        tbl[3]  = mk(1, OPI, 3'b001, 7'h20, 12'h000, 5'd10, 0, 4'b0000, 1, 4'b0000, 2'd0, 0, 2'b10, 5'd9);
        tbl[4]  = mk(1, OPI, 3'b011, 7'h00, 12'h000, 5'd11, 1, 4'b1101, 0, 4'b0000, 2'd0, 1, 2'b10, 5'd11);
        tbl[5]  = mk(1, OPR, 3'b000, 7'h20, 12'h000, 5'd12, 0, 4'b0100, 0, 4'b0000, 2'd0, 1, 2'b10, 5'd12);
        tbl[6]  = mk(1, OPR, 3'b101, 7'h20, 12'h000, 5'd13, 0, 4'b1010, 0, 4'b0000, 2'd0, 1, 2'b10, 5'd13);
        tbl[7]  = mk(1, OPR, 3'b011, 7'h00, 12'h000, 5'd14, 0, 4'b1101, 0, 4'b0000, 2'd0, 1, 2'b10, 5'd14);
        tbl[8]  = mk(1, OPR, 3'b110, 7'h00, 12'h000, 5'd15, 0, 4'b0010, 0, 4'b0000, 2'd0, 1, 2'b10, 5'd15);
        tbl[9]  = mk(1, OPR, 3'b001, 7'h20, 12'h000, 5'd16, 0, 4'b0000, 1, 4'b0000, 2'd0, 0, 2'b10, 5'd15);
        tbl[10] = mk(1, OPR, 3'b010, 7'h01, 12'h000, 5'd16, 0, 4'b0000, 1, 4'b0000, 2'd0, 0, 2'b10, 5'd15);
        tbl[11] = mk(1, LUI, 3'b000, 7'h00, 12'h000, 5'd17, 0, 4'b0011, 0, 4'b0000, 2'd0, 1, 2'b01, 5'd17);
        tbl[12] = mk(1, SYS, 3'b001, 7'h78, 12'hF02, 5'd3,  0, 4'b0000, 0, 4'b0100, 2'd2, 1, 2'b00, 5'd3);
        tbl[13] = mk(1, SYS, 3'b001, 7'h78, 12'hF03, 5'd4,  0, 4'b0000, 0, 4'b1000, 2'd3, 1, 2'b00, 5'd4);
        tbl[14] = mk(1, SYS, 3'b001, 7'h78, 12'hF07, 5'd18, 0, 4'b0000, 1, 4'b0000, 2'd0, 0, 2'b00, 5'd4);
        tbl[15] = mk(1, SYS, 3'b001, 7'h77, 12'hEFF, 5'd18, 0, 4'b0000, 1, 4'b0000, 2'd0, 0, 2'b00, 5'd4);
        tbl[16] = mk(1, SYS, 3'b010, 7'h78, 12'hF00, 5'd18, 0, 4'b0000, 1, 4'b0000, 2'd0, 0, 2'b00, 5'd4);
        tbl[17] = mk(1, 7'h00, 3'b000, 7'h00, 12'h000, 5'd18, 0, 4'b0000, 1, 4'b0000, 2'd0, 0, 2'b00, 5'd4);
        tbl[18] = mk(0, 7'h00, 3'b000, 7'h00, 12'h000, 5'd18, 0, 4'b0000, 0, 4'b0000, 2'd0, 0, 2'b00, 5'd4);
        tbl[19] = mk(0, OPI, 3'b000, 7'h00, 12'h000, 5'd20, 0, 4'b0000, 0, 4'b0000, 2'd0, 0, 2'b00, 5'd4);
        tbl[20] = mk(0, SYS, 3'b001, 7'h78, 12'hF01, 5'd20, 0, 4'b0000, 0, 4'b0000, 2'd0, 0, 2'b00, 5'd4);
        tbl[21] = mk(1, OPR, 3'b000, 7'h00, 12'h000, 5'd0,  0, 4'b0011, 0, 4'b0000, 2'd0, 0, 2'b10, 5'd0);
        tbl[22] = mk(1, OPR, 3'b101, 7'h00, 12'h000, 5'd1,  0, 4'b1001, 0, 4'b0000, 2'd0, 1, 2'b10, 5'd1);
        tbl[23] = mk(1, OPR, 3'b001, 7'h00, 12'h000, 5'd2,  0, 4'b1000, 0, 4'b0000, 2'd0, 1, 2'b10, 5'd2);
        tbl[24] = mk(1, OPI, 3'b111, 7'h00, 12'h000, 5'd21, 1, 4'b0001, 0, 4'b0000, 2'd0, 1, 2'b10, 5'd21);

        // Reset
        rst = 1'b1;
        valid_EX = 0; opcode_EX = '0; funct3_EX = '0; funct7_EX = '0;
        csr_EX = '0; rs1_EX = '0; rs2_EX = '0; rd_EX = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rst_regwrite", 16'(regwrite_WB), 16'd0);
        chk("rst_regsel",   16'(regsel_WB),   16'd0);
        chk("rst_rd",       16'(rd_WB),       16'd0);
        chk("rst_stall",    16'(stall),       16'd0);
        chk("rst_fwd",      16'({fwd_a, fwd_b}), 16'd0);

        // Table: combinational decode, then WB registers after the edge
        for (int i = 0; i < 25; i++) begin
            drv(tbl[i].v, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].csr, 5'd0, 5'd0, tbl[i].rd);
            chk($sformatf("v%0d_alusrc", i), 16'(alusrc),    16'(tbl[i].e_alusrc));
            chk($sformatf("v%0d_aluop", i),  16'(aluop),     16'(tbl[i].e_aluop));
            chk($sformatf("v%0d_illegal", i),16'(illegal),   16'(tbl[i].e_ill));
            chk($sformatf("v%0d_gpio_we", i),16'(gpio_we),   16'(tbl[i].e_we));
            chk($sformatf("v%0d_rsel", i),   16'(gpio_rsel), 16'(tbl[i].e_rsel));
            chk($sformatf("v%0d_stall", i),  16'(stall),     16'd0);
            edge_clk();
            chk($sformatf("v%0d_regwrite", i), 16'(regwrite_WB), 16'(tbl[i].e_rw));
            chk($sformatf("v%0d_regsel", i),   16'(regsel_WB),   16'(tbl[i].e_sel));
            chk($sformatf("v%0d_rd", i),       16'(rd_WB),       16'(tbl[i].e_rd));
        end

        // Forwarding: addi x5 then add x6,x5,x5
        drv(1, OPI, 3'b000, 7'h00, 12'h000, 5'd0, 5'd7, 5'd5);
        edge_clk();
        drv(1, OPR, 3'b000, 7'h00, 12'h000, 5'd5, 5'd5, 5'd6);
        chk("fwd_a_hit", 16'(fwd_a), 16'd1);
        chk("fwd_b_hit", 16'(fwd_b), 16'd1);
        chk("fwd_aluop", 16'(aluop), 16'b0011);
        chk("fwd_alusrc", 16'(alusrc), 16'd0);
        edge_clk();
        drv(1, OPR, 3'b000, 7'h00, 12'h000, 5'd1, 5'd6, 5'd7);
        chk("fwd_a_only_b", 16'(fwd_a), 16'd0);
        chk("fwd_b_only_b", 16'(fwd_b), 16'd1);
        edge_clk();
        drv(0, OPR, 3'b000, 7'h00, 12'h000, 5'd7, 5'd0, 5'd0);
        chk("fwd_a_bubble_ex", 16'(fwd_a), 16'd1);
        edge_clk();
        drv(1, OPR, 3'b000, 7'h00, 12'h000, 5'd7, 5'd7, 5'd8);
        chk("fwd_after_bubble", 16'({fwd_a, fwd_b}), 16'd0);
        edge_clk();
        drv(1, OPI, 3'b000, 7'h00, 12'h000, 5'd0, 5'd7, 5'd0);
        edge_clk();
        drv(1, OPR, 3'b000, 7'h00, 12'h000, 5'd0, 5'd0, 5'd6);
        chk("fwd_rd0", 16'({fwd_a, fwd_b}), 16'd0);
        chk("fwd_rd0_regwrite", 16'(regwrite_WB), 16'd0);
        edge_clk();

        // mul x7,x1,x2 held: stall 1,1,0 (latency 3); never on latency 1
        drv(1, OPR, 3'b000, 7'h01, 12'h000, 5'd1, 5'd2, 5'd7);
        chk("mul_c1_stall", 16'(stall), 16'd1);
        chk("mul_c1_aluop", 16'(aluop), 16'b0101);
        chk("mul1_c1_stall", 16'(stall1), 16'd0);
        edge_clk();
        chk("mul_e1_regwrite", 16'(regwrite_WB), 16'd0);
        chk("mul1_e1_wb", 16'({regwrite_WB1, rd_WB1}), 16'({1'b1, 5'd7}));
        #1;
        chk("mul_c2_stall", 16'(stall), 16'd1);
        chk("mul1_c2_stall", 16'(stall1), 16'd0);
        edge_clk();
        chk("mul_e2_regwrite", 16'(regwrite_WB), 16'd0);
        #1;
        chk("mul_c3_stall", 16'(stall), 16'd0);
        edge_clk();
        chk("mul_e3_regwrite", 16'(regwrite_WB), 16'd1);
        chk("mul_e3_rd", 16'(rd_WB), 16'd7);
        chk("mul_e3_sel", 16'(regsel_WB), 16'b10);

        // csrrw enters EX while still stalled: write enable must be held off
        drv(1, OPR, 3'b011, 7'h01, 12'h000, 5'd1, 5'd2, 5'd9);
        chk("mulhu_stall", 16'(stall), 16'd1);
        chk("mulhu_aluop", 16'(aluop), 16'b0111);
        edge_clk();
        drv(1, SYS, 3'b001, 7'h78, 12'hF02, 5'd1, 5'd0, 5'd3);
        chk("csr_stall", 16'(stall), 16'd1);
        chk("csr_stall_we", 16'(gpio_we), 16'b0000);
        chk("csr_stall_rsel", 16'(gpio_rsel), 16'd2);
        edge_clk();
        chk("csr_stall_regwrite", 16'(regwrite_WB), 16'd0);
        #1;
        chk("csr_go_stall", 16'(stall), 16'd0);
        chk("csr_go_we", 16'(gpio_we), 16'b0100);
        edge_clk();
        chk("csr_wb", 16'({regwrite_WB, regsel_WB, rd_WB}), 16'({1'b1, 2'b00, 5'd3}));

        // Abort by bubble while BUSY, then reissue
        drv(1, OPR, 3'b000, 7'h01, 12'h000, 5'd1, 5'd2, 5'd7);
        edge_clk();
        drv(0, OPR, 3'b000, 7'h01, 12'h000, 5'd1, 5'd2, 5'd7);
        chk("abort_stall", 16'(stall), 16'd0);
        edge_clk();
        chk("abort_regwrite", 16'(regwrite_WB), 16'd0);
        drv(1, OPR, 3'b001, 7'h01, 12'h000, 5'd1, 5'd2, 5'd7);
        chk("reissue_c1", 16'(stall), 16'd1);
        edge_clk();
        #1;
        chk("reissue_c2", 16'(stall), 16'd1);
        edge_clk();
        #1;
        chk("reissue_c3", 16'(stall), 16'd0);
        edge_clk();
        chk("reissue_wb", 16'({regwrite_WB, rd_WB}), 16'({1'b1, 5'd7}));

        // Reset in the second (BUSY) cycle of a mul
        drv(1, OPR, 3'b000, 7'h01, 12'h000, 5'd1, 5'd2, 5'd9);
        edge_clk();
        @(negedge clk);
        rst = 1'b1;
        edge_clk();
        @(negedge clk);
        rst = 1'b0;
        valid_EX = 1'b0;
        #2;
        chk("rstbusy_stall", 16'(stall), 16'd0);
        chk("rstbusy_wb", 16'({regwrite_WB, rd_WB}), 16'd0);
        edge_clk();
        drv(1, OPR, 3'b000, 7'h01, 12'h000, 5'd1, 5'd2, 5'd9);
        chk("rstbusy_c1", 16'(stall), 16'd1);
        edge_clk();
        chk("rstbusy_e1", 16'(regwrite_WB), 16'd0);
        #1;
        chk("rstbusy_c2", 16'(stall), 16'd1);
        edge_clk();
        #1;
        chk("rstbusy_c3", 16'(stall), 16'd0);
        edge_clk();
        chk("rstbusy_wb_done", 16'({regwrite_WB, rd_WB}), 16'({1'b1, 5'd9}));

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
